pwm_led_array: RTL and testbench

Parametrised multi-channel LED driver: replaces the fixed three-instance RGB blinker with one block driving `CHANNELS` outputs. Each channel has its own runtime speed and mode (off, on, blink, breathe). One shared PWM counter serves all channels. It sits between the chip top (oscillator clock, board reset input) and the LED pads.

---
 rtl/led_pkg.sv | 14 +
 rtl/led_channel.sv | 120 ++++++++++++
 rtl/pwm_led_array.sv | 47 ++++
 tb/tb_pwm_led_array.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and reset constants for the multi-channel LED driver.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } led_mode_t;

  localparam logic LED_RST = 1'b0;
  localparam logic CYC_RST = 1'b0;

endpackage

// File: rtl/led_channel.sv
// One LED channel: prescaler, latched mode, blink/breathe state and the
// registered led/cyc outputs.
module led_channel
  import led_pkg::*;
#(
  parameter int unsigned SPEED_W = 16,
  parameter int unsigned PWM_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode_i,
  input  logic [SPEED_W-1:0] speed_i,
  input  logic [PWM_W-1:0]   pwm_cnt,
  output logic               led,
  output logic               cyc
);

  localparam logic [PWM_W-1:0] MAX = '1;

  logic [SPEED_W-1:0] presc_q, presc_d;
  logic [PWM_W-1:0]   bright_q, bright_d;
  logic               dir_q, dir_d;
  logic               level_q, level_d;
  led_mode_t          mode_q, mode_d;
  logic               led_q, led_d;
  logic               cyc_q, cyc_d;
  led_mode_t          mode_new_c;
  logic               tick_c;

  assign mode_new_c = led_mode_t'(mode_i);

  always_comb begin
    presc_d  = presc_q;
    bright_d = bright_q;
    dir_d    = dir_q;
    level_d  = level_q;
    mode_d   = mode_q;
    led_d    = led_q;
    cyc_d    = 1'b0;
    tick_c   = 1'b0;

    // Output reflects the state already latched; held while disabled.
    if (en) begin
      case (mode_q)
        MODE_OFF:     led_d = 1'b0;
        MODE_ON:      led_d = 1'b1;
        MODE_BLINK:   led_d = level_q;
        MODE_BREATHE: led_d = (bright_q > pwm_cnt);
        default:      led_d = 1'b0;
      endcase
    end

    // A mode change reloads the channel and swallows any tick that cycle.
    if (mode_new_c != mode_q) begin
      presc_d  = '0;
      bright_d = '0;
      dir_d    = 1'b0;
      level_d  = 1'b0;
      mode_d   = mode_new_c;
    end else if (en && (speed_i != '0)) begin
      if (presc_q >= speed_i - SPEED_W'(1)) begin
        presc_d = '0;
        tick_c  = 1'b1;
      end else begin
        presc_d = presc_q + SPEED_W'(1);
      end
    end

    if (tick_c) begin
      case (mode_q)
        MODE_BLINK: begin
          level_d = ~level_q;
          cyc_d   = level_q;
        end
        MODE_BREATHE: begin
          if (!dir_q) begin
            if (bright_q == MAX) begin
              bright_d = MAX - PWM_W'(1);
              dir_d    = 1'b1;
            end else begin
              bright_d = bright_q + PWM_W'(1);
            end
          end else if (bright_q == '0) begin
            bright_d = PWM_W'(1);
            dir_d    = 1'b0;
            cyc_d    = 1'b1;
          end else begin
            bright_d = bright_q - PWM_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q  <= '0;
      bright_q <= '0;
      dir_q    <= 1'b0;
      level_q  <= 1'b0;
      mode_q   <= MODE_OFF;
      led_q    <= LED_RST;
      cyc_q    <= CYC_RST;
    end else begin
      presc_q  <= presc_d;
      bright_q <= bright_d;
      dir_q    <= dir_d;
      level_q  <= level_d;
      mode_q   <= mode_d;
      led_q    <= led_d;
      cyc_q    <= cyc_d;
    end
  end

  assign led = led_q;
  assign cyc = cyc_q;

endmodule

// File: rtl/pwm_led_array.sv
// Multi-channel LED driver: one shared PWM counter feeding CHANNELS
// independent blink/breathe channels.
module pwm_led_array
  import led_pkg::*;
#(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned SPEED_W  = 16,
  parameter int unsigned PWM_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [2*CHANNELS-1:0]       mode,
  input  logic [SPEED_W*CHANNELS-1:0] speed,
  output logic [CHANNELS-1:0]         led,
  output logic [CHANNELS-1:0]         cyc
);

  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q;
    if (en) pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pwm_cnt_q <= '0;
    else      pwm_cnt_q <= pwm_cnt_d;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    led_channel #(
      .SPEED_W (SPEED_W),
      .PWM_W   (PWM_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .mode_i  (mode[2*i +: 2]),
      .speed_i (speed[SPEED_W*i +: SPEED_W]),
      .pwm_cnt (pwm_cnt_q),
      .led     (led[i]),
      .cyc     (cyc[i])
    );
  end

endmodule

// File: tb/tb_pwm_led_array.sv
// Scoreboard bench for pwm_led_array: a phase-based reference model predicts
// led/cyc each cycle; a monitor pops and compares after every clock edge.
module tb_pwm_led_array;

  localparam int CH   = 3;
  localparam int SW   = 8;
  localparam int PW   = 4;
  localparam int MAXV = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en  = 1'b0;
  logic [2*CH-1:0] mode  = '0;
  logic [SW*CH-1:0] speed = '0;
  logic [CH-1:0]   led;
  logic [CH-1:0]   cyc;

  always #5 clk = ~clk;

  pwm_led_array #(
    .CHANNELS (CH),
    .SPEED_W  (SW),
    .PWM_W    (PW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .mode  (mode),
    .speed (speed),
    .led   (led),
    .cyc   (cyc)
  );

  logic [2*CH-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: breathe position is a phase 0..2*MAX (0 only after reload),
  // blink is a level bit, prescaler is cycles elapsed since the last tick.
  int          m_mode[CH];
  int          m_cnt[CH];
  int          m_ph[CH];
  bit          m_lvl[CH];
  logic [CH-1:0] m_led = '0;
  int          m_pwm = 0;
  int          cycle_no = 0;

  function automatic int bright_of(int ph);
    return (ph <= MAXV) ? ph : 2*MAXV - ph;
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [CH-1:0] el;
    logic [CH-1:0] ec;
    el = '0;
    ec = '0;
    for (int i = 0; i < CH; i++) begin
      int mi;
      int sp;
      bit tick;
      mi   = int'(mode[2*i +: 2]);
      sp   = int'(speed[SW*i +: SW]);
      tick = 1'b0;
      if (!rst) begin
        m_mode[i] = 0; m_cnt[i] = 0; m_ph[i] = 0; m_lvl[i] = 1'b0;
      end else begin
        if (en) begin
          case (m_mode[i])
            0:       el[i] = 1'b0;
            1:       el[i] = 1'b1;
            2:       el[i] = m_lvl[i];
            default: el[i] = (bright_of(m_ph[i]) > m_pwm);
          endcase
        end else begin
          el[i] = m_led[i];
        end
        if (mi != m_mode[i]) begin
          m_mode[i] = mi; m_cnt[i] = 0; m_ph[i] = 0; m_lvl[i] = 1'b0;
        end else if (en && sp != 0) begin
          m_cnt[i]++;
          if (m_cnt[i] >= sp) begin
            m_cnt[i] = 0;
            tick = 1'b1;
          end
        end
        if (tick && m_mode[i] == 2) begin
          ec[i]    = m_lvl[i];
          m_lvl[i] = !m_lvl[i];
        end else if (tick && m_mode[i] == 3) begin
          if (m_ph[i] == 2*MAXV) begin
            ec[i]   = 1'b1;
            m_ph[i] = 1;
          end else begin
            m_ph[i]++;
          end
        end
      end
    end
    if (!rst)    m_pwm = 0;
    else if (en) m_pwm = (m_pwm + 1) % (MAXV + 1);
    m_led = el;
    exp_q.push_back({el, ec});
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #2;
    cycle_no++;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [2*CH-1:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if ({led, cyc} !== e) begin
        n_err++;
        $display("FAIL scoreboard cycle %0d: led=%b cyc=%b, expected led=%b cyc=%b",
                 cycle_no, led, cyc, e[2*CH-1:CH], e[CH-1:0]);
      end
    end
  end

  initial begin
    int toggles;
    int pulses;
    int highs;
    int guard;
    logic [CH-1:0] prev;
    logic [CH-1:0] snap;

    // Reset held with all channels ON
    mode  = 6'b01_01_01;
    speed = {8'd3, 8'd3, 8'd3};
    en    = 1'b1;
    #1 rst = 1'b0;
    @(posedge clk);
    #2;
    repeat (5) begin
      step();
      check("reset_led", int'(led), 0);
      check("reset_cyc", int'(cyc), 0);
    end
    rst = 1'b1;
    step();
    check("release_led_edge1", int'(led), 0);
    step();
    check("release_led_edge2", int'(led), 7);

    // Blink on ch0, speed 3
    mode  = {2'd0, 2'd0, 2'd2};
    speed = {8'd0, 8'd0, 8'd3};
    repeat (10) step();
    toggles = 0; pulses = 0; prev = led;
    repeat (36) begin
      step();
      if (led[0] != prev[0]) toggles++;
      if (cyc[0]) pulses++;
      prev = led;
    end
    check("blink_toggles_36", toggles, 12);
    check("blink_cyc_36", pulses, 6);

    // Breathe on ch1, speed 1
    mode  = {2'd0, 2'd3, 2'd0};
    speed = {8'd0, 8'd1, 8'd0};
    repeat (40) step();
    pulses = 0;
    repeat (90) begin
      step();
      if (cyc[1]) pulses++;
    end
    check("breathe_cyc_90", pulses, 3);
    guard = 0;
    while (bright_of(m_ph[1]) != 8 && guard < 64) begin
      step();
      guard++;
    end
    check("breathe_reach_8", bright_of(m_ph[1]), 8);
    speed[15:8] = 8'd0;
    step();
    step();
    highs = 0;
    repeat (16) begin
      step();
      if (led[1]) highs++;
    end
    check("breathe_duty_8_16", highs, 8);

    // Halted prescaler, then speed drop mid-count
    mode[1:0]  = 2'd2;
    speed[7:0] = 8'd0;
    step();
    step();
    toggles = 0; prev = led;
    repeat (100) begin
      step();
      if (led[0] != prev[0]) toggles++;
      prev = led;
    end
    check("halt_no_toggle", toggles, 0);
    speed[7:0] = 8'd200;
    guard = 0;
    while (m_cnt[0] != 50 && guard < 300) begin
      step();
      guard++;
    end
    check("halt_count_50", m_cnt[0], 50);
    speed[7:0] = 8'd2;
    step();
    step();
    toggles = 0; prev = led;
    repeat (20) begin
      step();
      if (led[0] != prev[0]) toggles++;
      prev = led;
    end
    check("speed_drop_toggles", toggles, 10);

    // Mode switch mid-ramp on ch2
    mode[5:4]   = 2'd3;
    speed[23:16] = 8'd1;
    guard = 0;
    while (m_ph[2] != 10 && guard < 64) begin
      step();
      guard++;
    end
    check("switch_reach_10", m_ph[2], 10);
    mode[5:4] = 2'd2;
    step();
    check("switch_blink_cyc", int'(cyc[2]), 0);
    mode[5:4] = 2'd3;
    step();
    check("switch_breathe_cyc", int'(cyc[2]), 0);
    step();
    check("switch_after_cyc", int'(cyc[2]), 0);
    repeat (40) step();

    // Enable low freezes everything
    mode  = {2'd3, 2'd3, 2'd2};
    speed = {8'd1, 8'd1, 8'd1};
    repeat (25) step();
    en = 1'b0;
    snap = led;
    repeat (20) begin
      step();
      check("en_low_led", int'(led), int'(snap));
      check("en_low_cyc", int'(cyc), 0);
    end
    en = 1'b1;
    repeat (10) step();

    // Asynchronous reset between edges
    mode = 6'b01_01_01;
    repeat (3) step();
    check("pre_async_led", int'(led), 7);
    #2 rst = 1'b0;
    #1;
    check("async_reset_led", int'(led), 0);
    check("async_reset_cyc", int'(cyc), 0);
    repeat (3) step();
    rst = 1'b1;
    repeat (5) step();

    // Randomised mode/speed/enable traffic
    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) begin
        int c;
        c = $urandom_range(0, CH - 1);
        mode[2*c +: 2]   = 2'($urandom_range(0, 3));
        speed[SW*c +: SW] = 8'($urandom_range(0, 5));
      end
      en = ($urandom_range(0, 7) != 0);
      step();
    end

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
